// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Central hazard and forwarding controller for the 5-stage pipeline. Branches
// resolve in ID, so besides the EX-stage forwarding selects it also drives the
// ID comparator forwarding selects and sequences multi-cycle stalls when a
// branch depends on a load that is still in EX.
//
// Ports
//   CLK, RST                        clock (rising edge), async active-low reset
//   OpCode, Ctrl_Branch,
//   Branch_Taken                    IF/ID instruction decode and ID comparator
//   IfId_Rs/Rt, IdEx_Rs/Rt/Rd,
//   ExMem_Rd, MemWb_Rd              register numbers from pipeline registers
//   *_MemRead, *_Reg_Wr_Control     load / register-write flags per stage
//   FwdRs, FwdRt                    EX operand select (00 RF, 10 ExMem, 01 MemWb)
//   Fwd_IfId_Rs, Fwd_IfId_Rt        ID comparator operand select, same encoding
//   Stall, Flush, FwdPc             pipeline control (Mealy)
//   Busy                            multi-cycle stall in progress
//   Stall_Cnt, Flush_Cnt            saturating event counters
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [5:0]  OP_JUMP = 6'h02,
    parameter logic [5:0]  OP_BEQ  = 6'h04,
    parameter logic [5:0]  OP_SW   = 6'h2B
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       OpCode,
    input  logic             Ctrl_Branch,
    input  logic             Branch_Taken,
    input  logic [4:0]       IfId_Rs,
    input  logic [4:0]       IfId_Rt,
    input  logic [4:0]       IdEx_Rs,
    input  logic [4:0]       IdEx_Rt,
    input  logic [4:0]       IdEx_Rd,
    input  logic             IdEx_MemRead,
    input  logic             IdEx_Reg_Wr_Control,
    input  logic [4:0]       ExMem_Rd,
    input  logic             ExMem_MemRead,
    input  logic             ExMem_Reg_Wr_Control,
    input  logic [4:0]       MemWb_Rd,
    input  logic             MemWb_Reg_Wr_Control,
    output logic [1:0]       FwdRs,
    output logic [1:0]       FwdRt,
    output logic [1:0]       Fwd_IfId_Rs,
    output logic [1:0]       Fwd_IfId_Rt,
    output logic             Stall,
    output logic             Flush,
    output logic             FwdPc,
    output logic             Busy,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_uses_rt;
    logic w_match_ex;
    logic w_match_mem;
    logic w_h2;
    logic w_h1;
    logic w_redirect;
    logic w_stall;
    logic w_flush;
    logic w_fwdpc;

    // ExMem has priority over MemWb because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       exm_wr,
        input logic [4:0] exm_rd,
        input logic       mwb_wr,
        input logic [4:0] mwb_rd
    );
        if (exm_wr && (exm_rd != 5'd0) && (exm_rd == src))
            return 2'b10;
        else if (mwb_wr && (mwb_rd != 5'd0) && (mwb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // True when destination x is a source of the instruction in ID; Rt only
    // counts for R-type, BEQ and SW.
    function automatic logic reg_match(
        input logic [4:0] x,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_uses_rt   = (OpCode == 6'h00) || (OpCode == OP_BEQ) || (OpCode == OP_SW);
    assign w_match_ex  = reg_match(IdEx_Rd,  IfId_Rs, IfId_Rt, w_uses_rt);
    assign w_match_mem = reg_match(ExMem_Rd, IfId_Rs, IfId_Rt, w_uses_rt);

    // A branch needing a load result still in EX waits two cycles; every other
    // hazard is a single bubble and is re-checked after the pipeline advances.
    assign w_h2 = Ctrl_Branch && IdEx_MemRead && w_match_ex;
    assign w_h1 = (IdEx_MemRead && w_match_ex) ||
                  (Ctrl_Branch && ((IdEx_Reg_Wr_Control && w_match_ex) ||
                                   (ExMem_MemRead && w_match_mem)));
    assign w_redirect = (Ctrl_Branch && Branch_Taken) || (OpCode == OP_JUMP);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_fwdpc      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_h2) begin
                    w_stall      = 1'b1;
                    w_cnt_next   = 2'd1;
                    w_next_state = S_STALL;
                end else if (w_h1) begin
                    w_stall = 1'b1;
                end else if (w_redirect) begin
                    w_flush = 1'b1;
                    w_fwdpc = 1'b1;
                end
            end
            S_STALL: begin
                w_stall    = 1'b1;
                w_cnt_next = r_cnt - 2'd1;
                if (r_cnt <= 2'd1)
                    w_next_state = S_RUN;
            end
            default: w_next_state = S_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    // All control outputs are held quiet for as long as reset is low.
    assign Stall       = RST && w_stall;
    assign Flush       = RST && w_flush;
    assign FwdPc       = RST && w_fwdpc;
    assign Busy        = RST && (r_state == S_STALL);
    assign FwdRs       = RST ? fwd_sel(IdEx_Rs, ExMem_Reg_Wr_Control, ExMem_Rd,
                                       MemWb_Reg_Wr_Control, MemWb_Rd) : 2'b00;
    assign FwdRt       = RST ? fwd_sel(IdEx_Rt, ExMem_Reg_Wr_Control, ExMem_Rd,
                                       MemWb_Reg_Wr_Control, MemWb_Rd) : 2'b00;
    assign Fwd_IfId_Rs = RST ? fwd_sel(IfId_Rs, ExMem_Reg_Wr_Control, ExMem_Rd,
                                       MemWb_Reg_Wr_Control, MemWb_Rd) : 2'b00;
    assign Fwd_IfId_Rt = RST ? fwd_sel(IfId_Rt, ExMem_Reg_Wr_Control, ExMem_Rd,
                                       MemWb_Reg_Wr_Control, MemWb_Rd) : 2'b00;
    assign Stall_Cnt   = r_stall_cnt;
    assign Flush_Cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic [5:0]       OpCode;
    logic             Ctrl_Branch, Branch_Taken;
    logic [4:0]       IfId_Rs, IfId_Rt, IdEx_Rs, IdEx_Rt, IdEx_Rd, ExMem_Rd, MemWb_Rd;
    logic             IdEx_MemRead, IdEx_Reg_Wr_Control;
    logic             ExMem_MemRead, ExMem_Reg_Wr_Control, MemWb_Reg_Wr_Control;
    logic [1:0]       FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt;
    logic             Stall, Flush, FwdPc, Busy;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .OpCode(OpCode),
        .Ctrl_Branch(Ctrl_Branch), .Branch_Taken(Branch_Taken),
        .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
        .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt), .IdEx_Rd(IdEx_Rd),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_Reg_Wr_Control(IdEx_Reg_Wr_Control),
        .ExMem_Rd(ExMem_Rd), .ExMem_MemRead(ExMem_MemRead),
        .ExMem_Reg_Wr_Control(ExMem_Reg_Wr_Control),
        .MemWb_Rd(MemWb_Rd), .MemWb_Reg_Wr_Control(MemWb_Reg_Wr_Control),
        .FwdRs(FwdRs), .FwdRt(FwdRt), .Fwd_IfId_Rs(Fwd_IfId_Rs), .Fwd_IfId_Rt(Fwd_IfId_Rt),
        .Stall(Stall), .Flush(Flush), .FwdPc(FwdPc), .Busy(Busy),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    // ---------------- behavioural model ----------------
    // m_rem = stall cycles still owed after the cycle that detected the hazard.
    int         m_rem, m_scnt, m_fcnt, e_need;
    logic       e_stall, e_flush, e_fwdpc, e_busy;
    logic [1:0] e_frs, e_frt, e_fids, e_fidt;

    function automatic logic [1:0] fwd_exp(input logic [4:0] src, input logic exw,
                                           input logic [4:0] exd, input logic wbw,
                                           input logic [4:0] wbd);
        if (src == 5'd0) return 2'b00;
        if (exw && exd == src) return 2'b10;
        if (wbw && wbd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit reads_reg(input logic [4:0] x, input logic [5:0] op,
                                     input logic [4:0] rs, input logic [4:0] rt);
        bit rt_used;
        rt_used = (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
        if (x == 5'd0) return 1'b0;
        return (x == rs) || (rt_used && x == rt);
    endfunction

    always_comb begin
        e_stall = 1'b0; e_flush = 1'b0; e_fwdpc = 1'b0; e_busy = 1'b0;
        e_frs = 2'b00; e_frt = 2'b00; e_fids = 2'b00; e_fidt = 2'b00;
        e_need = 0;
        if (Ctrl_Branch && IdEx_MemRead && reads_reg(IdEx_Rd, OpCode, IfId_Rs, IfId_Rt))
            e_need = 2;
        else if ((IdEx_MemRead && reads_reg(IdEx_Rd, OpCode, IfId_Rs, IfId_Rt)) ||
                 (Ctrl_Branch && IdEx_Reg_Wr_Control && reads_reg(IdEx_Rd, OpCode, IfId_Rs, IfId_Rt)) ||
                 (Ctrl_Branch && ExMem_MemRead && reads_reg(ExMem_Rd, OpCode, IfId_Rs, IfId_Rt)))
            e_need = 1;
        if (RST === 1'b1) begin
            e_frs  = fwd_exp(IdEx_Rs, ExMem_Reg_Wr_Control, ExMem_Rd, MemWb_Reg_Wr_Control, MemWb_Rd);
            e_frt  = fwd_exp(IdEx_Rt, ExMem_Reg_Wr_Control, ExMem_Rd, MemWb_Reg_Wr_Control, MemWb_Rd);
            e_fids = fwd_exp(IfId_Rs, ExMem_Reg_Wr_Control, ExMem_Rd, MemWb_Reg_Wr_Control, MemWb_Rd);
            e_fidt = fwd_exp(IfId_Rt, ExMem_Reg_Wr_Control, ExMem_Rd, MemWb_Reg_Wr_Control, MemWb_Rd);
            if (m_rem > 0) begin
                e_stall = 1'b1;
                e_busy  = 1'b1;
            end else if (e_need > 0) begin
                e_stall = 1'b1;
            end else if ((Ctrl_Branch && Branch_Taken) || OpCode == 6'h02) begin
                e_flush = 1'b1;
                e_fwdpc = 1'b1;
            end
        end
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_rem  <= 0;
            m_scnt <= 0;
            m_fcnt <= 0;
        end else begin
            if (e_stall) m_scnt <= (m_scnt >= MAXC) ? MAXC : m_scnt + 1;
            if (e_flush) m_fcnt <= (m_fcnt >= MAXC) ? MAXC : m_fcnt + 1;
            if (m_rem > 0)       m_rem <= m_rem - 1;
            else if (e_need > 0) m_rem <= e_need - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("m_Stall", {31'd0, Stall}, {31'd0, e_stall});
        check("m_Flush", {31'd0, Flush}, {31'd0, e_flush});
        check("m_FwdPc", {31'd0, FwdPc}, {31'd0, e_fwdpc});
        check("m_Busy",  {31'd0, Busy},  {31'd0, e_busy});
        check("m_FwdRs", {30'd0, FwdRs}, {30'd0, e_frs});
        check("m_FwdRt", {30'd0, FwdRt}, {30'd0, e_frt});
        check("m_FwdIdRs", {30'd0, Fwd_IfId_Rs}, {30'd0, e_fids});
        check("m_FwdIdRt", {30'd0, Fwd_IfId_Rt}, {30'd0, e_fidt});
        check("m_StallCnt", {30'd0, Stall_Cnt}, m_scnt);
        check("m_FlushCnt", {30'd0, Flush_Cnt}, m_fcnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        OpCode = 6'h00; Ctrl_Branch = 0; Branch_Taken = 0;
        IfId_Rs = 0; IfId_Rt = 0; IdEx_Rs = 0; IdEx_Rt = 0; IdEx_Rd = 0;
        IdEx_MemRead = 0; IdEx_Reg_Wr_Control = 0;
        ExMem_Rd = 0; ExMem_MemRead = 0; ExMem_Reg_Wr_Control = 0;
        MemWb_Rd = 0; MemWb_Reg_Wr_Control = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b0;
        next_cycle();
        RST = 1'b1;
    endtask

    task automatic set_h2();
        idle();
        Ctrl_Branch = 1; IdEx_MemRead = 1; IdEx_Rd = 4; IfId_Rt = 4; OpCode = 6'h04;
    endtask

    logic [5:0] ops [5];

    initial begin
        ops = '{6'h00, 6'h02, 6'h04, 6'h2B, 6'h23};
        idle();
        RST = 1'b0;
        #1;
        // reset holds everything quiet even with a hazard on the inputs
        IdEx_MemRead = 1; IdEx_Rd = 7; IfId_Rs = 7;
        ExMem_Reg_Wr_Control = 1; ExMem_Rd = 7; IdEx_Rs = 7;
        #1;
        check("rst_Stall", {31'd0, Stall}, 0);
        check("rst_FwdRs", {30'd0, FwdRs}, 0);
        check("rst_Busy", {31'd0, Busy}, 0);
        check("rst_StallCnt", {30'd0, Stall_Cnt}, 0);
        next_cycle();
        do_reset();

        // EX forwarding priority
        ExMem_Reg_Wr_Control = 1; ExMem_Rd = 5; MemWb_Reg_Wr_Control = 1; MemWb_Rd = 5;
        IdEx_Rs = 5; IdEx_Rt = 3;
        #2;
        check("fwd_Rs_exmem", {30'd0, FwdRs}, 2'b10);
        check("fwd_Rt_none", {30'd0, FwdRt}, 2'b00);
        ExMem_Rd = 0;
        #2;
        check("fwd_Rs_memwb", {30'd0, FwdRs}, 2'b01);
        next_cycle();

        // load-use: one bubble
        do_reset();
        IdEx_MemRead = 1; IdEx_Rd = 7; IfId_Rs = 7; OpCode = 6'h00;
        #2;
        check("lu_Stall", {31'd0, Stall}, 1);
        check("lu_Busy", {31'd0, Busy}, 0);
        next_cycle();
        idle();
        #2;
        check("lu_StallCnt", {30'd0, Stall_Cnt}, 1);
        check("lu_Stall_after", {31'd0, Stall}, 0);
        IdEx_MemRead = 1; IdEx_Rd = 0; IfId_Rs = 0;
        #2;
        check("lu_r0_Stall", {31'd0, Stall}, 0);
        next_cycle();

        // load then branch: two stall cycles
        do_reset();
        set_h2();
        MemWb_Rd = 4; MemWb_Reg_Wr_Control = 1;
        #2;
        check("lb_Stall1", {31'd0, Stall}, 1);
        check("lb_Busy1", {31'd0, Busy}, 0);
        check("lb_FwdIdRt", {30'd0, Fwd_IfId_Rt}, 2'b01);
        next_cycle();
        idle();
        #2;
        check("lb_Stall2", {31'd0, Stall}, 1);
        check("lb_Busy2", {31'd0, Busy}, 1);
        next_cycle();
        #2;
        check("lb_Stall3", {31'd0, Stall}, 0);
        check("lb_Busy3", {31'd0, Busy}, 0);
        check("lb_StallCnt", {30'd0, Stall_Cnt}, 2);

        // taken branch and jump
        do_reset();
        Ctrl_Branch = 1; Branch_Taken = 1;
        #2;
        check("br_FwdPc", {31'd0, FwdPc}, 1);
        check("br_Flush", {31'd0, Flush}, 1);
        next_cycle();
        idle();
        #2;
        check("br_FlushCnt", {30'd0, Flush_Cnt}, 1);
        check("br_Flush_after", {31'd0, Flush}, 0);
        OpCode = 6'h02;
        #2;
        check("j_FwdPc", {31'd0, FwdPc}, 1);
        check("j_Flush", {31'd0, Flush}, 1);
        next_cycle();
        idle();
        #2;
        check("j_FlushCnt", {30'd0, Flush_Cnt}, 2);

        // stall wins over redirect
        do_reset();
        Ctrl_Branch = 1; Branch_Taken = 1; OpCode = 6'h04;
        IdEx_Reg_Wr_Control = 1; IdEx_Rd = 9; IfId_Rs = 9;
        #2;
        check("sr_Stall", {31'd0, Stall}, 1);
        check("sr_Flush", {31'd0, Flush}, 0);
        check("sr_FwdPc", {31'd0, FwdPc}, 0);
        next_cycle();

        // reset during the second stall cycle
        do_reset();
        set_h2();
        next_cycle();
        idle();
        #1;
        check("rs_Busy_before", {31'd0, Busy}, 1);
        RST = 1'b0;
        #1;
        check("rs_Stall", {31'd0, Stall}, 0);
        check("rs_Busy", {31'd0, Busy}, 0);
        check("rs_StallCnt", {30'd0, Stall_Cnt}, 0);
        #1;
        RST = 1'b1;
        #1;
        check("rs_Busy_release", {31'd0, Busy}, 0);
        check("rs_Stall_release", {31'd0, Stall}, 0);
        next_cycle();

        // saturation: load-use held for five cycles
        do_reset();
        IdEx_MemRead = 1; IdEx_Rd = 7; IfId_Rs = 7;
        repeat (5) next_cycle();
        check("sat_StallCnt", {30'd0, Stall_Cnt}, 3);

        // r0 never forwards
        do_reset();
        ExMem_Reg_Wr_Control = 1; ExMem_Rd = 0; MemWb_Reg_Wr_Control = 1; MemWb_Rd = 0;
        IdEx_Rs = 0; IfId_Rs = 0;
        #2;
        check("r0_FwdRs", {30'd0, FwdRs}, 0);
        check("r0_FwdIdRs", {30'd0, Fwd_IfId_Rs}, 0);
        next_cycle();

        // mixed vectors, checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            OpCode = ops[$urandom_range(0, 4)];
            Ctrl_Branch = 1'($urandom_range(0, 1));
            Branch_Taken = 1'($urandom_range(0, 1));
            IfId_Rs = 5'($urandom_range(0, 3)); IfId_Rt = 5'($urandom_range(0, 3));
            IdEx_Rs = 5'($urandom_range(0, 3)); IdEx_Rt = 5'($urandom_range(0, 3));
            IdEx_Rd = 5'($urandom_range(0, 3)); ExMem_Rd = 5'($urandom_range(0, 3));
            MemWb_Rd = 5'($urandom_range(0, 3));
            IdEx_MemRead = 1'($urandom_range(0, 1));
            IdEx_Reg_Wr_Control = 1'($urandom_range(0, 1));
            ExMem_MemRead = 1'($urandom_range(0, 1));
            ExMem_Reg_Wr_Control = 1'($urandom_range(0, 1));
            MemWb_Reg_Wr_Control = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) begin
                RST = 1'b0;
                #2;
                RST = 1'b1;
            end
            next_cycle();
        end

        idle();
        repeat (3) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central hazard and forwarding controller for the 5-stage pipelined datapath. It generates the Stall, Flush, FwdPc and four forwarding-select controls from the pipeline-register fields the datapath exports. Branches resolve in ID, so it also sequences multi-cycle stalls through a small FSM with a stall counter. It keeps saturating stall/flush event counters for bring-up.

Parameters:
CNT_W, 16, width of Stall_Cnt / Flush_Cnt
OP_JUMP, 6'h02, opcode of unconditional jump
OP_BEQ, 6'h04, opcode of branch-equal (reads Rt)
OP_SW, 6'h2B, opcode of store word (reads Rt)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  reset; asynchronous, active-low
OpCode  in  6  opcode of instruction in IF/ID
Ctrl_Branch  in  1  IF/ID instruction is a conditional branch
Branch_Taken  in  1  ID-stage comparator result (valid when Ctrl_Branch)
IfId_Rs, IfId_Rt  in  5 each  source regs in ID
IdEx_Rs, IdEx_Rt  in  5 each  source regs in EX
IdEx_Rd  in  5  destination (post-RegDst) of EX instruction
IdEx_MemRead, IdEx_Reg_Wr_Control  in  1 each  EX instruction is load / writes reg
ExMem_Rd  in  5  destination in MEM
ExMem_MemRead, ExMem_Reg_Wr_Control  in  1 each  MEM instruction is load / writes reg
MemWb_Rd  in  5  destination in WB
MemWb_Reg_Wr_Control  in  1  WB instruction writes reg
FwdRs, FwdRt  out  2 each  EX operand select: 00 regfile, 10 ExMem, 01 MemWb
Fwd_IfId_Rs, Fwd_IfId_Rt  out  2 each  ID comparator operand select, same encoding
Stall  out  1  freeze PC and IF/ID, bubble into ID/EX
Flush  out  1  zero IF/ID on next edge
FwdPc  out  1  PC mux selects branch/jump target
Busy  out  1  FSM not in RUN
Stall_Cnt, Flush_Cnt  out  CNT_W each  saturating event counters

Behaviour:
- Forwarding is combinational. For FwdRs: 10 if ExMem_Reg_Wr_Control & ExMem_Rd!=0 & ExMem_Rd==IdEx_Rs; else 01 if MemWb_Reg_Wr_Control & MemWb_Rd!=0 & MemWb_Rd==IdEx_Rs; else 00. ExMem has priority. FwdRt, Fwd_IfId_Rs and Fwd_IfId_Rt use the same rule on their own source register.
- uses_rt = OpCode in {6'h00, OP_BEQ, OP_SW}.
- match(x) = x!=0 & (x==IfId_Rs | (uses_rt & x==IfId_Rt)).
- Hazard conditions, evaluated in RUN only:
  - H2 (2 cycles) = Ctrl_Branch & IdEx_MemRead & match(IdEx_Rd).
  - H1 (1 cycle) = either of:
    - IdEx_MemRead & match(IdEx_Rd) (load-use), or
    - Ctrl_Branch & ((IdEx_Reg_Wr_Control & match(IdEx_Rd)) | (ExMem_MemRead & match(ExMem_Rd))).
- FSM states: RUN, STALL; 2-bit down-counter cnt.
  - RUN, H2: Stall=1, cnt<=1, next STALL.
  - RUN, H1 and not H2: Stall=1, next RUN. The condition re-evaluates next cycle; the pipeline has advanced.
  - RUN, no hazard, (Ctrl_Branch & Branch_Taken) or OpCode==OP_JUMP: FwdPc=1, Flush=1 for that cycle only.
  - STALL: Stall=1. If cnt==1, next RUN; cnt decrements each cycle.
- Priority: Stall over redirect. Flush and FwdPc are never asserted in a cycle with Stall=1.
- Stall, Flush and FwdPc are Mealy outputs from RUN/STALL plus inputs. Busy = (state==STALL).
- Counters:
  - Stall_Cnt increments every cycle Stall=1; Flush_Cnt increments every cycle Flush=1.
  - Both saturate at all-ones and never wrap.
- Reset: RST low asynchronously forces state=RUN, cnt=0 and both counters=0, and forces Stall=Flush=FwdPc=Busy=0 and all four Fwd selects=00 while low. Reset mid-STALL abandons the stall; the first cycle after release evaluates in RUN.
- Register 0 never matches. A write to r0 produces no forwarding and no stall.

Test Plan:
- EX forwarding: ExMem_Reg_Wr_Control=1, ExMem_Rd=5, MemWb_Reg_Wr_Control=1, MemWb_Rd=5, IdEx_Rs=5, IdEx_Rt=3 -> FwdRs=10, FwdRt=00. Set ExMem_Rd=0 -> FwdRs=01.
- Load-use: RUN, IdEx_MemRead=1, IdEx_Rd=7, IfId_Rs=7, OpCode=0 -> Stall=1 one cycle, Busy=0, Stall_Cnt=1. Same with IdEx_Rd=0 -> Stall=0.
- Load then branch: Ctrl_Branch=1, IdEx_MemRead=1, IdEx_Rd=4, IfId_Rt=4, OpCode=OP_BEQ -> Stall=1 for exactly 2 cycles, Busy=1 in the second, then RUN. With MemWb_Rd=4 and MemWb_Reg_Wr_Control=1 -> Fwd_IfId_Rt=01.
- Taken branch, no hazard: Ctrl_Branch=1, Branch_Taken=1 -> FwdPc=1 and Flush=1 for one cycle, Flush_Cnt=1. Jump opcode 6'h02 gives the same result.
- Stall versus redirect: branch with an ALU hazard (IdEx_Reg_Wr_Control=1, IdEx_Rd=IfId_Rs) and Branch_Taken=1 -> Stall=1, Flush=0, FwdPc=0 that cycle.
- Reset mid-STALL: drop RST during the second stall cycle -> all outputs 0 immediately, counters 0, RUN after release. Counter saturation with CNT_W=2: 5 stall cycles -> Stall_Cnt=3.
